// File: rtl/semaforo_sensor.sv
// Traffic-light sensor/checker: per-street car queues with timed departures,
// yield requests to the light controller, and a sticky light-protocol checker.
module semaforo_sensor #(
    parameter int unsigned DEPART_CYCLES = 2,
    parameter int unsigned MAX_GREEN     = 8,
    parameter int unsigned MIN_YELLOW    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       car_a,
    input  logic       car_b,
    input  logic [1:0] LA,
    input  logic [1:0] LB,
    output logic       TA,
    output logic       TB,
    output logic [3:0] queue_a,
    output logic [3:0] queue_b,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int unsigned QW = 4;
    localparam int unsigned TW = (DEPART_CYCLES < 2) ? 1 : $clog2(DEPART_CYCLES + 1);
    localparam int unsigned GW = $clog2(MAX_GREEN + 1);
    localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
    localparam logic [QW-1:0] Q_MAX = QW'(15);

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        RED     = 2'b10,
        ILLEGAL = 2'b11
    } light_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CONFLICT = 2'b01;
    localparam logic [1:0] ERR_TRANS    = 2'b10;
    localparam logic [1:0] ERR_SHORT_Y  = 2'b11;

    logic [1:0]    light  [2];
    logic          car    [2];
    logic [QW-1:0] q_r    [2], q_n    [2];
    logic [TW-1:0] tmr_r  [2], tmr_n  [2];
    logic [GW-1:0] age_r  [2], age_n  [2];
    logic [YW-1:0] ycnt_r [2], ycnt_n [2];
    light_t        last_r [2];
    logic          yield_n [2];
    logic          bad_trans [2];
    logic          short_y   [2];
    logic          conflict;
    logic [1:0]    viol;

    assign light[0] = LA;
    assign light[1] = LB;
    assign car[0]   = car_a;
    assign car[1]   = car_b;

    // Per-street queue, departure timer, green age, yellow length and yield request
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic green;
            logic dep;
            logic [QW-1:0] q_other;
            q_n[i]       = q_r[i];
            tmr_n[i]     = '0;
            age_n[i]     = '0;
            ycnt_n[i]    = '0;
            yield_n[i]   = 1'b0;
            bad_trans[i] = 1'b0;
            short_y[i]   = 1'b0;
            q_other      = (i == 0) ? q_r[1] : q_r[0];
            green        = (light[i] == GREEN);
            dep          = green && (tmr_r[i] == TW'(DEPART_CYCLES - 1)) && (q_r[i] != '0);

            // Arrival at a full queue is dropped; departure still applies
            unique case ({car[i], dep})
                2'b10:   q_n[i] = (q_r[i] == Q_MAX) ? q_r[i] : q_r[i] + QW'(1);
                2'b01:   q_n[i] = q_r[i] - QW'(1);
                2'b11:   q_n[i] = (q_r[i] == Q_MAX) ? Q_MAX - QW'(1) : q_r[i];
                default: q_n[i] = q_r[i];
            endcase

            // Timer parks at its terminal count while the queue is empty
            if (green && !dep)
                tmr_n[i] = (tmr_r[i] == TW'(DEPART_CYCLES - 1)) ? tmr_r[i] : tmr_r[i] + TW'(1);

            if (green)
                age_n[i] = (age_r[i] == GW'(MAX_GREEN)) ? age_r[i] : age_r[i] + GW'(1);

            if (light[i] == YELLOW)
                ycnt_n[i] = (ycnt_r[i] == YW'(MIN_YELLOW)) ? ycnt_r[i] : ycnt_r[i] + YW'(1);

            yield_n[i] = green && (q_other != '0) &&
                         ((q_r[i] == '0) || (age_r[i] >= GW'(MAX_GREEN)));

            bad_trans[i] = (light[i] == ILLEGAL) ||
                           !((light[i] == last_r[i]) ||
                             (last_r[i] == GREEN  && light[i] == YELLOW) ||
                             (last_r[i] == YELLOW && light[i] == RED)    ||
                             (last_r[i] == RED    && light[i] == GREEN));

            short_y[i] = (last_r[i] == YELLOW) && (light[i] == RED) &&
                         (ycnt_r[i] < YW'(MIN_YELLOW));
        end
    end

    // Violation classification with conflict > transition > short-yellow priority
    always_comb begin
        conflict = (LA != RED) && (LB != RED);
        viol     = ERR_NONE;
        if (conflict)
            viol = ERR_CONFLICT;
        else if (bad_trans[0] || bad_trans[1])
            viol = ERR_TRANS;
        else if (short_y[0] || short_y[1])
            viol = ERR_SHORT_Y;
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                q_r[i]    <= '0;
                tmr_r[i]  <= '0;
                age_r[i]  <= '0;
                ycnt_r[i] <= '0;
                last_r[i] <= RED;
            end
            TA       <= 1'b0;
            TB       <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            for (int i = 0; i < 2; i++) begin
                q_r[i]    <= q_n[i];
                tmr_r[i]  <= tmr_n[i];
                age_r[i]  <= age_n[i];
                ycnt_r[i] <= ycnt_n[i];
                last_r[i] <= light_t'(light[i]);
            end
            TA <= yield_n[0];
            TB <= yield_n[1];
            if (!error && viol != ERR_NONE) begin
                error    <= 1'b1;
                err_code <= viol;
            end
        end
    end

    assign queue_a = q_r[0];
    assign queue_b = q_r[1];

endmodule
